// File: rtl/vga_pkg.sv
// Shared VGA 640x480 timing constants, the 3-bit colour type and the cell-row address helper.
// No logic state; pure compile-time definitions.
package vga_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int H_TOTAL    = 800;
    localparam int V_ACTIVE   = 480;
    localparam int V_TOTAL    = 525;
    localparam int CELL_SHIFT = 2;

    typedef logic [2:0] rgb3_t;

    // cy*160 built from two shifts so no multiplier is inferred
    function automatic logic [14:0] cell_row_base(input logic [6:0] cy);
        return {1'b0, cy, 7'b0} + {3'b0, cy, 5'b0};
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// N-stage register chain that keeps sync/enable strobes aligned with the registered pixel path.
// Latency N cycles; no backpressure, shifts every cycle.
module vga_sync_delay #(
    parameter int               WIDTH   = 1,
    parameter int               N       = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [N];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[N-1];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer BRAM between VGA scan-out (reserved slots) and a host port.
// Pixel out 1 cycle after counts; host read data 1 cycle after accept; host stalled only in fetch slots.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int   CELLS_X   = 160,
    parameter int   CELLS_Y   = 120,
    parameter int   ADDR_W    = 15,
    parameter logic SYNC_IDLE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        h_count,
    input  logic [9:0]        v_count,
    input  logic              display_en,
    input  logic              h_sync_in,
    input  logic              v_sync_in,
    input  logic              blank,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_wdata,
    output logic              rsp_valid,
    output logic [2:0]        rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [2:0]        mem_wdata,
    input  logic [2:0]        mem_rdata,
    output logic [2:0]        rgb_out,
    output logic              hsync_out,
    output logic              vsync_out
);

    localparam int NUM_CELLS = CELLS_X * CELLS_Y;

    logic [9:0]        h_ahead;
    logic [9:0]        fx;
    logic [9:0]        fetch_line;
    logic              display_slot;
    logic [ADDR_W-1:0] disp_addr;
    logic              in_range;
    logic              host_acc;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        wdata_q;
    logic              disp_pend;
    logic              rsp_oob;
    rgb3_t             cell_reg;
    logic [1:0]        sync_d;

    // Look two pixels ahead: the fetch issued now must land before the next cell starts.
    always_comb begin
        h_ahead = (h_count >= 10'(H_TOTAL - 2)) ? h_count - 10'(H_TOTAL - 2) : h_count + 10'd2;
        fx      = h_ahead >> CELL_SHIFT;
        if (h_count == 10'(H_TOTAL - 2))
            fetch_line = (v_count == 10'(V_TOTAL - 1)) ? 10'd0 : v_count + 10'd1;
        else
            fetch_line = v_count;
        display_slot = reset && (h_count[1:0] == 2'd2) && (fx < 10'(CELLS_X))
                    && (fetch_line < 10'(V_ACTIVE)) && !blank;
        disp_addr = ADDR_W'(cell_row_base(7'(fetch_line >> CELL_SHIFT))) + ADDR_W'(fx);
    end

    assign req_ready = reset && !display_slot;
    assign host_acc  = req_valid && req_ready;
    assign in_range  = req_addr < ADDR_W'(NUM_CELLS);

    // Out-of-range host requests are accepted but leave the BRAM port parked.
    always_comb begin
        mem_addr  = addr_q;
        mem_we    = 1'b0;
        mem_wdata = wdata_q;
        if (display_slot) begin
            mem_addr = disp_addr;
        end else if (host_acc && in_range) begin
            mem_addr = req_addr;
            mem_we   = req_we;
            if (req_we) mem_wdata = req_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            disp_pend <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_oob   <= 1'b0;
            cell_reg  <= '0;
            rgb_out   <= '0;
        end else begin
            addr_q    <= mem_addr;
            wdata_q   <= mem_wdata;
            disp_pend <= display_slot;
            rsp_valid <= host_acc && !req_we;
            rsp_oob   <= !in_range;
            if (disp_pend) cell_reg <= mem_rdata;
            rgb_out   <= (display_en && !blank) ? cell_reg : '0;
        end
    end

    // disp_pend marks the cycle whose read data belongs to scan-out, never to the host.
    assign rsp_rdata = (rsp_valid && !rsp_oob && !disp_pend) ? mem_rdata : 3'b000;

    vga_sync_delay #(
        .WIDTH   (2),
        .N       (1),
        .RST_VAL ({SYNC_IDLE, SYNC_IDLE})
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .din   ({h_sync_in, v_sync_in}),
        .dout  (sync_d)
    );

    assign hsync_out = sync_d[1];
    assign vsync_out = sync_d[0];

endmodule
